gen_reg_bank: RTL and testbench
===============================

Name: gen_reg_bank

Overview:
- Parametrised register bank: PA_NREG general registers plus one program counter.
- One write port with enable, two registered read ports, and PC auto-increment.
- Unlike the fixed 1-to-17 demux, unselected registers hold their value instead of clearing.
- Invalid write selects are flagged.
- Sits between the writeback path and the operand-fetch stage of the core.

Parameters:
PA_DATA, 32, data width of every register and port
PA_NREG, 16, number of general registers (1..PA_PC_SEL); valid indices 0..PA_NREG-1
PA_SEL, 9, width of all select buses
PA_PC_SEL, 9'h0FF, select code addressing the PC
PA_PC_INC, 4, increment added to PC on pc_inc_en
PA_PC_RST, 0, PC reset value

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
wr_en  in  1  write strobe
wr_sel  in  PA_SEL  write target: 0..PA_NREG-1 or PA_PC_SEL
wr_data  in  PA_DATA  write data
pc_inc_en  in  1  advance PC by PA_PC_INC
rd_sel_a  in  PA_SEL  read port A select (same encoding as wr_sel)
rd_sel_b  in  PA_SEL  read port B select
rd_data_a  out  PA_DATA  registered read data A
rd_data_b  out  PA_DATA  registered read data B
pc  out  PA_DATA  current PC (direct register output)
wr_err  out  1  one-cycle pulse: previous-cycle write had an invalid select
wr_cnt  out  16  count of accepted writes, wraps 0xFFFF->0

Behaviour:
- Clock is clk. Reset is rst: synchronous and active-high, sampled on the rising edge of clk, dominating all other inputs.
- Reset values:
  - all general registers 0
  - pc = PA_PC_RST
  - rd_data_a = rd_data_b = 0
  - wr_err = 0
  - wr_cnt = 0
- Reset mid-operation discards any same-cycle write or increment.
- Writes:
  - If wr_en and wr_sel < PA_NREG: reg[wr_sel] <= wr_data at the edge.
  - All other registers hold.
  - wr_cnt increments by 1.
- PC update priority, evaluated per edge:
  - wr_en and wr_sel == PA_PC_SEL: pc <= wr_data; pc_inc_en is ignored that cycle; wr_cnt increments.
  - Else if pc_inc_en: pc <= pc + PA_PC_INC, modulo 2^PA_DATA (wraps, no flag).
  - Else pc holds.
- Invalid write (wr_en and wr_sel neither < PA_NREG nor == PA_PC_SEL):
  - No state change and wr_cnt unchanged.
  - wr_err = 1 for exactly the next cycle.
  - wr_err = 0 whenever the prior cycle had no invalid write.
- Reads have 1-cycle latency: rd_data_x at edge N+1 reflects rd_sel_x sampled at edge N.
  - sel < PA_NREG returns reg[sel].
  - sel == PA_PC_SEL returns pc.
  - Any other sel returns 0.
- Write-to-read bypass:
  - Same-cycle wr_en and rd_sel_x == wr_sel (valid target): rd_data_x returns wr_data, the new value, not the old one.
  - For the PC, bypass applies only to an explicit write, never to an increment; a read alongside an increment returns the pre-increment pc.
- Both read ports are independent and may select the same register.
- pc output always shows the stored PC with no bypass; it reflects a write or increment one edge after it is requested.
- Elaboration: PA_NREG must be <= PA_PC_SEL and <= 2^PA_SEL - 1, otherwise a fatal elaboration error.

Test Plan:
- Reset: drive rst=1 for 2 cycles with wr_en=1, wr_sel=3, wr_data=0xDEADBEEF -> after release, read sel 3 returns 0, pc=0, wr_cnt=0, wr_err=0.
- Write then hold: write 0x12345678 to reg 5, then 3 idle cycles, then read A sel 5 and read B sel 4 -> A=0x12345678, B=0; reg 5 unchanged after a write to reg 6.
- Bypass: same cycle wr_en=1, wr_sel=7, wr_data=0xA5A5A5A5, rd_sel_a=7 -> next cycle rd_data_a=0xA5A5A5A5; wr_cnt=1.
- PC priority and wrap:
  - pc_inc_en=1 for 3 cycles -> pc=12.
  - Then wr_en=1, wr_sel=0x0FF, wr_data=0xFFFFFFFC with pc_inc_en=1 -> pc=0xFFFFFFFC.
  - Next pc_inc_en=1 -> pc=0x00000000.
- Invalid select: wr_en=1, wr_sel=0x020, wr_data=0x1 -> wr_err=1 for exactly one cycle, wr_cnt unchanged, read sel 0x020 returns 0, all registers unchanged.
- Counter wrap and mid-stream reset: force 65536 valid writes -> wr_cnt returns to 0; assert rst during a write to reg 2 -> reg 2 reads 0 afterwards.

Source files
------------

// File: rtl/gen_reg_bank_if.sv
// gen_reg_bank_if: write, read and PC-increment signals of the register bank
interface gen_reg_bank_if #(
   parameter int PA_DATA = 32,
   parameter int PA_SEL = 9
);
   logic wr_en;
   logic [PA_SEL-1:0] wr_sel;
   logic [PA_DATA-1:0] wr_data;
   logic pc_inc_en;
   logic [PA_SEL-1:0] rd_sel_a;
   logic [PA_SEL-1:0] rd_sel_b;
   logic [PA_DATA-1:0] rd_data_a;
   logic [PA_DATA-1:0] rd_data_b;
   logic [PA_DATA-1:0] pc;
   logic wr_err;
   logic [15:0] wr_cnt;
   modport master (
      output wr_en, wr_sel, wr_data, pc_inc_en, rd_sel_a, rd_sel_b,
      input rd_data_a, rd_data_b, pc, wr_err, wr_cnt
   );
   modport slave (
      input wr_en, wr_sel, wr_data, pc_inc_en, rd_sel_a, rd_sel_b,
      output rd_data_a, rd_data_b, pc, wr_err, wr_cnt
   );
endinterface

// File: rtl/gen_reg_bank.sv
// gen_reg_bank: general registers plus PC with write port, two registered read ports and PC increment
module gen_reg_bank #(
   parameter int PA_DATA = 32,
   parameter int PA_NREG = 16,
   parameter int PA_SEL = 9,
   parameter logic [PA_SEL-1:0] PA_PC_SEL = 9'h0FF,
   parameter int PA_PC_INC = 4,
   parameter int PA_PC_RST = 0
) (
   input logic clk,
   input logic rst,
   gen_reg_bank_if.slave bus
);
   localparam int IW = PA_NREG > 1 ? $clog2(PA_NREG) : 1;
   if (PA_NREG < 1 || PA_NREG > int'(PA_PC_SEL) || PA_NREG > 2 ** PA_SEL - 1) begin : g_chk
      $fatal(1, "gen_reg_bank: PA_NREG out of range");
   end
   logic [PA_DATA-1:0] regs [PA_NREG];
   logic [PA_DATA-1:0] pc;
   logic [PA_DATA-1:0] rd_a;
   logic [PA_DATA-1:0] rd_b;
   logic [15:0] cnt;
   logic err;
   logic wr_reg;
   logic wr_pc;
   logic wr_inv;
   always_comb begin
      wr_reg = bus.wr_en && ({1'b0, bus.wr_sel} < (PA_SEL+1)'(PA_NREG));
      wr_pc = bus.wr_en && bus.wr_sel == PA_PC_SEL;
      wr_inv = bus.wr_en && !wr_reg && !wr_pc;
   end
   // an explicit write to the selected target is forwarded; PC increments never are
   function automatic logic [PA_DATA-1:0] rd_val(input logic [PA_SEL-1:0] s);
      return ((wr_reg || wr_pc) && s == bus.wr_sel) ? bus.wr_data :
             ({1'b0, s} < (PA_SEL+1)'(PA_NREG)) ? regs[s[IW-1:0]] :
             (s == PA_PC_SEL) ? pc : '0;
   endfunction
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < PA_NREG; i++) regs[i] <= '0;
         pc <= PA_DATA'(PA_PC_RST);
         rd_a <= '0;
         rd_b <= '0;
         cnt <= '0;
         err <= 1'b0;
      end else begin
         if (wr_reg) regs[bus.wr_sel[IW-1:0]] <= bus.wr_data;
         pc <= wr_pc ? bus.wr_data : bus.pc_inc_en ? pc + PA_DATA'(PA_PC_INC) : pc;
         rd_a <= rd_val(bus.rd_sel_a);
         rd_b <= rd_val(bus.rd_sel_b);
         cnt <= cnt + 16'((wr_reg || wr_pc) ? 1 : 0);
         err <= wr_inv;
      end
   end
   assign bus.rd_data_a = rd_a;
   assign bus.rd_data_b = rd_b;
   assign bus.pc = pc;
   assign bus.wr_err = err;
   assign bus.wr_cnt = cnt;
endmodule

// File: tb/tb_gen_reg_bank.sv
// tb_gen_reg_bank: directed tests of gen_reg_bank with hand-computed expectations
module tb_gen_reg_bank;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int total = 0;
   int passed = 0;
   gen_reg_bank_if #(.PA_DATA(32), .PA_SEL(9)) bus ();
   gen_reg_bank dut (.clk(clk), .rst(rst), .bus(bus.slave));
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.wr_en = 1'b0;
      bus.wr_sel = '0;
      bus.wr_data = '0;
      bus.pc_inc_en = 1'b0;
      bus.rd_sel_a = '0;
      bus.rd_sel_b = '0;
   endtask

   task automatic apply_reset();
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.wr_en = 1'b1;
      bus.wr_sel = 9'd3;
      bus.wr_data = 32'hDEADBEEF;
      tick();
      tick();
      rst = 1'b0;
      idle();
      bus.rd_sel_a = 9'd3;
      tick();
      total++; if (bus.rd_data_a !== 32'h0) $display("FAIL reset_reg3 got %h want 0", bus.rd_data_a); else passed++;
      total++; if (bus.pc !== 32'h0) $display("FAIL reset_pc got %h want 0", bus.pc); else passed++;
      total++; if (bus.wr_cnt !== 16'h0) $display("FAIL reset_cnt got %h want 0", bus.wr_cnt); else passed++;
      total++; if (bus.wr_err !== 1'b0) $display("FAIL reset_err got %b want 0", bus.wr_err); else passed++;
   endtask

   task automatic test_write_hold();
      apply_reset();
      bus.wr_en = 1'b1;
      bus.wr_sel = 9'd5;
      bus.wr_data = 32'h12345678;
      tick();
      idle();
      repeat (3) tick();
      bus.rd_sel_a = 9'd5;
      bus.rd_sel_b = 9'd4;
      tick();
      total++; if (bus.rd_data_a !== 32'h12345678) $display("FAIL hold_a got %h want 12345678", bus.rd_data_a); else passed++;
      total++; if (bus.rd_data_b !== 32'h0) $display("FAIL hold_b got %h want 0", bus.rd_data_b); else passed++;
      bus.wr_en = 1'b1;
      bus.wr_sel = 9'd6;
      bus.wr_data = 32'h66666666;
      tick();
      idle();
      bus.rd_sel_a = 9'd5;
      bus.rd_sel_b = 9'd6;
      tick();
      total++; if (bus.rd_data_a !== 32'h12345678) $display("FAIL hold_after_w6 got %h want 12345678", bus.rd_data_a); else passed++;
      total++; if (bus.rd_data_b !== 32'h66666666) $display("FAIL read_reg6 got %h want 66666666", bus.rd_data_b); else passed++;
      total++; if (bus.wr_cnt !== 16'd2) $display("FAIL hold_cnt got %0d want 2", bus.wr_cnt); else passed++;
   endtask

   task automatic test_bypass();
      apply_reset();
      bus.wr_en = 1'b1;
      bus.wr_sel = 9'd7;
      bus.wr_data = 32'hA5A5A5A5;
      bus.rd_sel_a = 9'd7;
      bus.rd_sel_b = 9'd7;
      tick();
      idle();
      total++; if (bus.rd_data_a !== 32'hA5A5A5A5) $display("FAIL bypass_a got %h want a5a5a5a5", bus.rd_data_a); else passed++;
      total++; if (bus.rd_data_b !== 32'hA5A5A5A5) $display("FAIL bypass_b got %h want a5a5a5a5", bus.rd_data_b); else passed++;
      total++; if (bus.wr_cnt !== 16'd1) $display("FAIL bypass_cnt got %0d want 1", bus.wr_cnt); else passed++;
   endtask

   task automatic test_pc();
      apply_reset();
      bus.pc_inc_en = 1'b1;
      repeat (3) tick();
      total++; if (bus.pc !== 32'd12) $display("FAIL pc_inc got %h want c", bus.pc); else passed++;
      bus.wr_en = 1'b1;
      bus.wr_sel = 9'h0FF;
      bus.wr_data = 32'hFFFFFFFC;
      bus.rd_sel_a = 9'h0FF;
      tick();
      total++; if (bus.pc !== 32'hFFFFFFFC) $display("FAIL pc_write_prio got %h want fffffffc", bus.pc); else passed++;
      total++; if (bus.rd_data_a !== 32'hFFFFFFFC) $display("FAIL pc_bypass got %h want fffffffc", bus.rd_data_a); else passed++;
      total++; if (bus.wr_cnt !== 16'd1) $display("FAIL pc_cnt got %0d want 1", bus.wr_cnt); else passed++;
      bus.wr_en = 1'b0;
      tick();
      total++; if (bus.pc !== 32'h0) $display("FAIL pc_wrap got %h want 0", bus.pc); else passed++;
      total++; if (bus.rd_data_a !== 32'hFFFFFFFC) $display("FAIL pc_read_pre_inc got %h want fffffffc", bus.rd_data_a); else passed++;
      idle();
   endtask

   task automatic test_invalid();
      apply_reset();
      bus.wr_en = 1'b1;
      bus.wr_sel = 9'd1;
      bus.wr_data = 32'h11;
      tick();
      bus.wr_sel = 9'h020;
      bus.wr_data = 32'h1;
      bus.rd_sel_a = 9'h020;
      bus.rd_sel_b = 9'd1;
      tick();
      idle();
      total++; if (bus.wr_err !== 1'b1) $display("FAIL inv_err got %b want 1", bus.wr_err); else passed++;
      total++; if (bus.wr_cnt !== 16'd1) $display("FAIL inv_cnt got %0d want 1", bus.wr_cnt); else passed++;
      total++; if (bus.rd_data_a !== 32'h0) $display("FAIL inv_read got %h want 0", bus.rd_data_a); else passed++;
      total++; if (bus.rd_data_b !== 32'h11) $display("FAIL inv_reg1 got %h want 11", bus.rd_data_b); else passed++;
      bus.rd_sel_a = 9'd0;
      tick();
      total++; if (bus.wr_err !== 1'b0) $display("FAIL inv_err_clear got %b want 0", bus.wr_err); else passed++;
      total++; if (bus.rd_data_a !== 32'h0) $display("FAIL inv_reg0 got %h want 0", bus.rd_data_a); else passed++;
      total++; if (bus.pc !== 32'h0) $display("FAIL inv_pc got %h want 0", bus.pc); else passed++;
   endtask

   task automatic test_cnt_wrap_reset();
      apply_reset();
      bus.wr_en = 1'b1;
      bus.wr_sel = 9'd0;
      for (int i = 0; i < 65535; i++) begin
         bus.wr_data = 32'(i);
         tick();
      end
      total++; if (bus.wr_cnt !== 16'hFFFF) $display("FAIL cnt_max got %h want ffff", bus.wr_cnt); else passed++;
      bus.wr_sel = 9'd2;
      bus.wr_data = 32'h55;
      tick();
      total++; if (bus.wr_cnt !== 16'h0) $display("FAIL cnt_wrap got %h want 0", bus.wr_cnt); else passed++;
      bus.wr_data = 32'h77;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      idle();
      bus.rd_sel_a = 9'd2;
      tick();
      total++; if (bus.rd_data_a !== 32'h0) $display("FAIL rst_mid_reg2 got %h want 0", bus.rd_data_a); else passed++;
      total++; if (bus.wr_cnt !== 16'h0) $display("FAIL rst_mid_cnt got %h want 0", bus.wr_cnt); else passed++;
   endtask

   initial begin
      idle();
      test_reset();
      test_write_hold();
      test_bypass();
      test_pc();
      test_invalid();
      test_cnt_wrap_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
